// File: rtl/csa_resolver.sv
// rtl/csa_resolver.sv - chunked carry-propagate adder resolving a CSA (sum, carry) pair
module csa_resolver #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   sum_in,
    input  logic [WIDTH-1:0]   carry_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH+1:0]   result,
    output logic               busy
);

    localparam int NCH = (WIDTH + 2 + CHUNK - 1) / CHUNK;
    localparam int PW  = NCH * CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   op_a;
    logic [PW-1:0]   op_b;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic            cc;
    logic [CHUNK:0]  chunk_sum;

    // Operands shift right one chunk per RUN cycle, so the active chunk is always at bit 0.
    always_comb begin
        chunk_sum = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, cc};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, resolve NCH chunks in RUN, hold in DONE until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on acceptance, then add one chunk per cycle, rippling the carry.
    // Each resolved chunk enters acc at the top and moves down, so after NCH cycles chunk 0
    // sits at bit 0 and the whole sum is in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
            acc  <= '0;
            cnt  <= '0;
            cc   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a <= PW'(sum_in);
                        op_b <= PW'({carry_in, 1'b0});
                        acc  <= '0;
                        cnt  <= '0;
                        cc   <= 1'b0;
                    end
                end
                RUN: begin
                    op_a <= op_a >> CHUNK;
                    op_b <= op_b >> CHUNK;
                    acc  <= (acc >> CHUNK) | (PW'(chunk_sum[CHUNK-1:0]) << (PW - CHUNK));
                    cc   <= chunk_sum[CHUNK];
                    cnt  <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Padding bits above WIDTH+1 are always zero and are discarded.
    if (PW > WIDTH + 2) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^acc[PW-1:WIDTH+2];
    end

    assign result    = acc[WIDTH+1:0];
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule
